// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit adder driving an external 4-bit fa4 slice one nibble per cycle, LSB first; optional subtract via NIBBLE_SERIAL_ADDER_SUBTRACT_EN.
// Latency: out_valid rises WIDTH/4 cycles after the accepting edge; next accept no sooner than WIDTH/4+2 cycles.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef NIBBLE_SERIAL_ADDER_SUBTRACT_EN
  input  logic             in_sub,
`endif
  output logic [3:0]       fa_a,
  output logic [3:0]       fa_b,
  output logic             fa_cin,
  input  logic [3:0]       fa_sum,
  input  logic             fa_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = $clog2(NIB);
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             accept;
  logic             last;

  assign accept = in_valid && in_ready;
  assign last   = (state == RUN) && (idx == LAST);

  // Subtraction is a + ~b + 1; the forced carry-in replaces in_cin.
  always_comb begin
    b_load = in_b;
    c_load = in_cin;
`ifdef NIBBLE_SERIAL_ADDER_SUBTRACT_EN
    if (in_sub) begin
      b_load = ~in_b;
      c_load = 1'b1;
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (idx == LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    fa_a      = 4'd0;
    fa_b      = 4'd0;
    fa_cin    = 1'b0;
    if (state == RUN) begin
      fa_a   = a_sh[3:0];
      fa_b   = b_sh[3:0];
      fa_cin = carry;
    end
  end

  // Partial sums build up in acc; out_sum only changes when an operation completes.
  always_comb begin
    acc_nxt = acc;
    acc_nxt[{idx, 2'b00} +: 4] = fa_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      acc      <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh  <= in_a;
            b_sh  <= b_load;
            carry <= c_load;
            idx   <= '0;
            acc   <= '0;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          carry <= fa_cout;
          a_sh  <= a_sh >> 4;
          b_sh  <= b_sh >> 4;
          if (last) begin
            out_sum  <= acc_nxt;
            out_cout <= fa_cout;
            idx      <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
